// File: rtl/multi_load_controller.sv
// Edge-triggered load sequencer: one loaddata strobe per accepted rising edge, steered via load_sel.
// Define CTRL_SYNC_EN to place a two-flop synchronizer on inputdata_ready.
module multi_load_controller #(
  parameter int unsigned NUM_OPS        = 2,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  localparam int unsigned SelW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  localparam int unsigned CntW = $clog2(HOLDOFF_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inputdata_ready,
  output logic            loaddata,
  output logic [SelW-1:0] load_sel,
  output logic            busy,
  output logic            op_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StDone} state_e;

  localparam logic [SelW-1:0] LastIdx  = SelW'(NUM_OPS - 1);
  localparam logic [CntW-1:0] HoldInit = CntW'(HOLDOFF_CYCLES - 1);

  state_e          state_q, state_d;
  logic [SelW-1:0] idx_q, idx_d;
  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic            rdy_s, rdy_prev_q, rdy_edge;

`ifdef CTRL_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= inputdata_ready;
      sync2_q <= sync1_q;
    end
  end

  assign rdy_s = sync2_q;
`else
  assign rdy_s = inputdata_ready;
`endif

  assign rdy_edge = rdy_s & ~rdy_prev_q;

  // rdy_prev tracks in every state, so a level held through HOLD never re-triggers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      hcnt_q     <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hcnt_q     <= hcnt_d;
      rdy_prev_q <= rdy_s;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      StIdle: begin
        if (rdy_edge) state_d = StLoad;
      end
      StLoad: begin
        state_d = StHold;
        hcnt_d  = HoldInit;
      end
      StHold: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - CntW'(1);
        end else if (!rdy_s) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + SelW'(1);
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        // New round goes straight to LOAD without an IDLE cycle.
        if (rdy_edge) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
      idx_d   = '0;
      hcnt_d  = '0;
    end
  end

  assign loaddata = (state_q == StLoad);
  assign busy     = (state_q == StLoad) || (state_q == StHold);
  assign op_done  = (state_q == StDone);
  assign load_sel = idx_q;

endmodule

// File: tb/tb_multi_load_controller.sv
// Randomized scoreboard bench for multi_load_controller (NUM_OPS=3, HOLDOFF_CYCLES=4).
// Honours CTRL_SYNC_EN by delaying the model's view of the input by two cycles.
module tb_multi_load_controller;

  localparam int unsigned NumOps  = 3;
  localparam int unsigned Holdoff = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       inputdata_ready;
  logic       loaddata;
  logic [1:0] load_sel;
  logic       busy;
  logic       op_done;

  multi_load_controller #(
    .NUM_OPS       (NumOps),
    .HOLDOFF_CYCLES(Holdoff)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .inputdata_ready(inputdata_ready),
    .loaddata       (loaddata),
    .load_sel       (load_sel),
    .busy           (busy),
    .op_done        (op_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld;
    bit bsy;
    bit dn;
    int sel;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Reference model: described by its observable rules, not by state encoding.
  bit m_prev, m_load, m_hold, m_done, m_s1, m_s2;
  int m_held, m_sel;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_load = 0; m_hold = 0; m_done = 0;
    m_s1 = 0; m_s2 = 0; m_held = 0; m_sel = 0;
  endtask

  task automatic model_step(input bit r, input bit c);
    bit rs, e;
`ifdef CTRL_SYNC_EN
    rs   = m_s2;
    m_s2 = m_s1;
    m_s1 = r;
`else
    rs = r;
`endif
    e = rs && !m_prev;
    if (c) begin
      m_load = 0; m_hold = 0; m_done = 0; m_sel = 0;
    end else if (m_load) begin
      m_load = 0; m_hold = 1; m_held = 0;
    end else if (m_hold) begin
      // At least Holdoff cycles held, and the source must have released.
      m_held++;
      if (m_held >= Holdoff && !rs) begin
        m_hold = 0;
        if (m_sel == NumOps - 1) m_done = 1;
        else m_sel++;
      end
    end else if (m_done) begin
      if (e) begin
        m_done = 0; m_sel = 0; m_load = 1;
      end
    end else if (e) begin
      m_load = 1;
    end
    m_prev = rs;
  endtask

  task automatic drive(input bit r, input bit c);
    exp_t x;
    @(negedge clk);
    inputdata_ready = r;
    clear = c;
    model_step(r, c);
    x.ld = m_load; x.bsy = m_load || m_hold; x.dn = m_done; x.sel = m_sel;
    exp_q.push_back(x);
    if (m_load) strobe_q.push_back(m_sel);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("loaddata", int'(loaddata), int'(x.ld));
      check("busy", int'(busy), int'(x.bsy));
      check("op_done", int'(op_done), int'(x.dn));
      check("load_sel", int'(load_sel), x.sel);
      if (loaddata) begin
        if (strobe_q.size() == 0) check("extra_strobe", 1, 0);
        else check("strobe_sel", int'(load_sel), strobe_q.pop_front());
      end
    end
  end

  initial begin
    int kind, hi, lo;
    model_reset();
    reset = 1'b0;
    clear = 1'b0;
    inputdata_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_loaddata", int'(loaddata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_op_done", int'(op_done), 0);
    check("rst_load_sel", int'(load_sel), 0);
    inputdata_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    // Directed full round: pulses high 2, low 6.
    for (int p = 0; p < NumOps; p++) begin
      repeat (2) drive(1, 0);
      repeat (6) drive(0, 0);
    end
    repeat (10) drive(0, 0);
    // Stuck-high then bounce.
    repeat (20) drive(1, 0);
    repeat (4) drive(0, 0);
    drive(1, 0); drive(0, 0); drive(1, 0); drive(0, 0); drive(1, 0);
    repeat (8) drive(0, 0);

    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat (20) drive(1, ($urandom_range(0, 39) == 0));
      end else if (kind == 1) begin
        for (int b = 0; b < 4; b++) drive(b[0] == 0, 0);
      end else begin
        hi = $urandom_range(1, 3);
        lo = $urandom_range(1, 8);
        repeat (hi) drive(1, ($urandom_range(0, 39) == 0));
        repeat (lo) drive(0, ($urandom_range(0, 39) == 0));
      end
    end
    repeat (12) drive(0, 0);
    @(posedge clk); #2;
    check("strobes_drained", strobe_q.size(), 0);

    // Asynchronous reset in the middle of a LOAD cycle.
    drive(0, 1);
    repeat (4) drive(0, 0);
    for (int i = 0; i < 5 && !m_load; i++) drive(1, 0);
    @(posedge clk); #2;
    check("pre_reset_load", int'(loaddata), 1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midload_rst_loaddata", int'(loaddata), 0);
    check("midload_rst_busy", int'(busy), 0);
    check("midload_rst_load_sel", int'(load_sel), 0);
    exp_q.delete();
    strobe_q.delete();
    model_reset();
    inputdata_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) drive(1, 0);
    repeat (10) drive(0, 0);
    @(posedge clk); #2;
    check("strobes_final", strobe_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
